// File: rtl/regfile_rn_pkg.sv
// Shared widths and constants for the rename-aware register file slice.
package regfile_rn_pkg;

    localparam int NAME_W    = 5;
    localparam int OP_W      = 8;
    localparam int ADDR_W    = 32;
    localparam int IMM_W     = 32;
    localparam int NICK_NONE = 0;

    typedef logic [NAME_W-1:0] name_t;
    typedef logic [OP_W-1:0]   op_t;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [IMM_W-1:0]  imm_t;

endpackage

// File: rtl/regfile_rn_resolve.sv
// Combinational operand priority chain for one source of one lane:
// x0, then older-lane rename, then matching commit, then stored value with commit data bypass.
module rn_operand_resolve
    import regfile_rn_pkg::*;
#(
    parameter int LANES  = 2,
    parameter int CMT    = 2,
    parameter int DATA_W = 32,
    parameter int NICK_W = 4
) (
    input  logic [NAME_W-1:0]              i_src,
    input  logic [LANES-1:0]               i_prior_we,
    input  logic [LANES-1:0][NAME_W-1:0]   i_prior_rd,
    input  logic [LANES-1:0][NICK_W-1:0]   i_prior_nick,
    input  logic [CMT-1:0]                 i_cmt_en,
    input  logic [CMT-1:0][NAME_W-1:0]     i_cmt_rd,
    input  logic [CMT-1:0][DATA_W-1:0]     i_cmt_dt,
    input  logic [CMT-1:0][NICK_W-1:0]     i_cmt_nick,
    input  logic [DATA_W-1:0]              i_reg_dt,
    input  logic [NICK_W-1:0]              i_reg_nick,
    output logic [DATA_W-1:0]              o_dt,
    output logic [NICK_W-1:0]              o_nick
);

    logic [LANES-1:0]  w_lane_hits;
    logic [CMT-1:0]    w_cmt_any;
    logic [CMT-1:0]    w_cmt_match;
    logic              w_lane_hit;
    logic [NICK_W-1:0] w_lane_nick;
    logic              w_match_hit;
    logic [DATA_W-1:0] w_match_dt;
    logic              w_any_hit;
    logic [DATA_W-1:0] w_any_dt;

    // Per-candidate hit vectors; the highest index wins in every class
    always_comb begin
        w_lane_hits = '0;
        w_cmt_any   = '0;
        w_cmt_match = '0;
        w_lane_hit  = 1'b0;
        w_lane_nick = '0;
        w_match_hit = 1'b0;
        w_match_dt  = '0;
        w_any_hit   = 1'b0;
        w_any_dt    = '0;
        for (int k = 0; k < LANES; k++) begin
            w_lane_hits[k] = i_prior_we[k] & (i_prior_rd[k] == i_src);
            w_lane_hit     = w_lane_hit | w_lane_hits[k];
            w_lane_nick    = w_lane_hits[k] ? i_prior_nick[k] : w_lane_nick;
        end
        for (int c = 0; c < CMT; c++) begin
            w_cmt_any[c]   = i_cmt_en[c] & (i_cmt_rd[c] == i_src);
            w_cmt_match[c] = w_cmt_any[c] & (i_cmt_nick[c] == i_reg_nick);
            w_any_hit      = w_any_hit | w_cmt_any[c];
            w_any_dt       = w_cmt_any[c] ? i_cmt_dt[c] : w_any_dt;
            w_match_hit    = w_match_hit | w_cmt_match[c];
            w_match_dt     = w_cmt_match[c] ? i_cmt_dt[c] : w_match_dt;
        end
    end

    // Final priority selection
    always_comb begin
        o_dt   = '0;
        o_nick = '0;
        if (i_src == '0) begin
            o_dt   = '0;
            o_nick = '0;
        end else if (w_lane_hit) begin
            o_dt   = '0;
            o_nick = w_lane_nick;
        end else if (w_match_hit) begin
            o_dt   = w_match_dt;
            o_nick = '0;
        end else if (w_any_hit) begin
            o_dt   = w_any_dt;
            o_nick = i_reg_nick;
        end else begin
            o_dt   = i_reg_dt;
            o_nick = i_reg_nick;
        end
    end

endmodule

// File: rtl/regfile_rn.sv
// Architectural register file with rename-tag table, multi-lane read/rename,
// multi-port in-order commit and a held operand stage that snoops commits while stalled.
module regfile_rn
    import regfile_rn_pkg::*;
#(
    parameter int LANES   = 2,
    parameter int CMT     = 2,
    parameter int REG_NUM = 32,
    parameter int DATA_W  = 32,
    parameter int NICK_W  = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            rdy,
    input  logic                            clr,
    input  logic                            iIND_en,
    output logic                            oIND_stall,
    input  logic [LANES-1:0][NAME_W-1:0]    iIND_rs1_regnm,
    input  logic [LANES-1:0][NAME_W-1:0]    iIND_rs2_regnm,
    input  logic [LANES-1:0][NAME_W-1:0]    iIND_rd_regnm,
    input  logic [LANES-1:0]                iIND_rd_we,
    input  logic [LANES-1:0][NICK_W-1:0]    iIND_nick,
    input  logic [LANES-1:0][OP_W-1:0]      iIND_op,
    input  logic [LANES-1:0][ADDR_W-1:0]    iIND_pc,
    input  logic [LANES-1:0][IMM_W-1:0]     iIND_imm,
    input  logic [LANES-1:0]                iIND_pd,
    output logic                            oDP_en,
    input  logic                            iDP_stall,
    output logic [LANES-1:0][DATA_W-1:0]    oDP_rs1_dt,
    output logic [LANES-1:0][DATA_W-1:0]    oDP_rs2_dt,
    output logic [LANES-1:0][NICK_W-1:0]    oDP_rs1_nick,
    output logic [LANES-1:0][NICK_W-1:0]    oDP_rs2_nick,
    output logic [LANES-1:0][NAME_W-1:0]    oDP_rd_regnm,
    output logic [LANES-1:0]                oDP_rd_we,
    output logic [LANES-1:0][NICK_W-1:0]    oDP_nick,
    output logic [LANES-1:0][OP_W-1:0]      oDP_op,
    output logic [LANES-1:0][ADDR_W-1:0]    oDP_pc,
    output logic [LANES-1:0][IMM_W-1:0]     oDP_imm,
    output logic [LANES-1:0]                oDP_pd,
    input  logic [CMT-1:0]                  iROB_en,
    input  logic [CMT-1:0][NAME_W-1:0]      iROB_rd_regnm,
    input  logic [CMT-1:0][DATA_W-1:0]      iROB_rd_dt,
    input  logic [CMT-1:0][NICK_W-1:0]      iROB_rd_nick
);

    logic [DATA_W-1:0] r_reg_dt   [REG_NUM];
    logic [NICK_W-1:0] r_reg_nick [REG_NUM];

    logic                         r_dp_en;
    logic [LANES-1:0][DATA_W-1:0] r_rs1_dt;
    logic [LANES-1:0][DATA_W-1:0] r_rs2_dt;
    logic [LANES-1:0][NICK_W-1:0] r_rs1_nick;
    logic [LANES-1:0][NICK_W-1:0] r_rs2_nick;
    logic [LANES-1:0][NAME_W-1:0] r_rd_regnm;
    logic [LANES-1:0]             r_rd_we;
    logic [LANES-1:0][NICK_W-1:0] r_nick;
    logic [LANES-1:0][OP_W-1:0]   r_op;
    logic [LANES-1:0][ADDR_W-1:0] r_pc;
    logic [LANES-1:0][IMM_W-1:0]  r_imm;
    logic [LANES-1:0]             r_pd;

    logic                         w_acc;
    logic [LANES-1:0][LANES-1:0]  w_prior_we;
    logic [LANES-1:0][DATA_W-1:0] w_rs1_dt;
    logic [LANES-1:0][DATA_W-1:0] w_rs2_dt;
    logic [LANES-1:0][NICK_W-1:0] w_rs1_nick;
    logic [LANES-1:0][NICK_W-1:0] w_rs2_nick;

    assign w_acc      = iIND_en & rst & ~clr & rdy & ~(r_dp_en & iDP_stall);
    assign oIND_stall = iIND_en & ~w_acc;

    // Only lanes older than l may forward a rename to lane l
    always_comb begin
        w_prior_we = '0;
        for (int l = 0; l < LANES; l++) begin
            for (int k = 0; k < LANES; k++) begin
                w_prior_we[l][k] = iIND_rd_we[k] & (k < l);
            end
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        rn_operand_resolve #(
            .LANES(LANES), .CMT(CMT), .DATA_W(DATA_W), .NICK_W(NICK_W)
        ) u_rs1 (
            .i_src(iIND_rs1_regnm[l]), .i_prior_we(w_prior_we[l]),
            .i_prior_rd(iIND_rd_regnm), .i_prior_nick(iIND_nick),
            .i_cmt_en(iROB_en), .i_cmt_rd(iROB_rd_regnm),
            .i_cmt_dt(iROB_rd_dt), .i_cmt_nick(iROB_rd_nick),
            .i_reg_dt(r_reg_dt[iIND_rs1_regnm[l]]),
            .i_reg_nick(r_reg_nick[iIND_rs1_regnm[l]]),
            .o_dt(w_rs1_dt[l]), .o_nick(w_rs1_nick[l])
        );
        rn_operand_resolve #(
            .LANES(LANES), .CMT(CMT), .DATA_W(DATA_W), .NICK_W(NICK_W)
        ) u_rs2 (
            .i_src(iIND_rs2_regnm[l]), .i_prior_we(w_prior_we[l]),
            .i_prior_rd(iIND_rd_regnm), .i_prior_nick(iIND_nick),
            .i_cmt_en(iROB_en), .i_cmt_rd(iROB_rd_regnm),
            .i_cmt_dt(iROB_rd_dt), .i_cmt_nick(iROB_rd_nick),
            .i_reg_dt(r_reg_dt[iIND_rs2_regnm[l]]),
            .i_reg_nick(r_reg_nick[iIND_rs2_regnm[l]]),
            .o_dt(w_rs2_dt[l]), .o_nick(w_rs2_nick[l])
        );
    end

    // Register storage: commit data, commit-clear of matching nicks, renames override clears
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                r_reg_dt[i]   <= '0;
                r_reg_nick[i] <= '0;
            end
        end else begin
            if (clr || rdy) begin
                for (int c = 0; c < CMT; c++) begin
                    if (iROB_en[c] && iROB_rd_regnm[c] != '0) begin
                        r_reg_dt[iROB_rd_regnm[c]] <= iROB_rd_dt[c];
                    end
                end
            end
            if (clr) begin
                for (int i = 0; i < REG_NUM; i++) begin
                    r_reg_nick[i] <= NICK_W'(NICK_NONE);
                end
            end else if (rdy) begin
                for (int c = 0; c < CMT; c++) begin
                    if (iROB_en[c] && iROB_rd_regnm[c] != '0 &&
                        r_reg_nick[iROB_rd_regnm[c]] == iROB_rd_nick[c]) begin
                        r_reg_nick[iROB_rd_regnm[c]] <= '0;
                    end
                end
                for (int l = 0; l < LANES; l++) begin
                    if (w_acc && iIND_rd_we[l] && iIND_rd_regnm[l] != '0) begin
                        r_reg_nick[iIND_rd_regnm[l]] <= iIND_nick[l];
                    end
                end
            end
        end
    end

    // Operand packet stage: capture on accept, snoop commits while held, drop when drained
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_dp_en    <= 1'b0;
            r_rs1_dt   <= '0;
            r_rs2_dt   <= '0;
            r_rs1_nick <= '0;
            r_rs2_nick <= '0;
            r_rd_regnm <= '0;
            r_rd_we    <= '0;
            r_nick     <= '0;
            r_op       <= '0;
            r_pc       <= '0;
            r_imm      <= '0;
            r_pd       <= '0;
        end else if (clr) begin
            r_dp_en <= 1'b0;
        end else if (!rdy) begin
            r_dp_en <= r_dp_en;
        end else if (w_acc) begin
            r_dp_en    <= 1'b1;
            r_rs1_dt   <= w_rs1_dt;
            r_rs2_dt   <= w_rs2_dt;
            r_rs1_nick <= w_rs1_nick;
            r_rs2_nick <= w_rs2_nick;
            r_rd_regnm <= iIND_rd_regnm;
            r_rd_we    <= iIND_rd_we;
            r_nick     <= iIND_nick;
            r_op       <= iIND_op;
            r_pc       <= iIND_pc;
            r_imm      <= iIND_imm;
            r_pd       <= iIND_pd;
        end else if (r_dp_en && iDP_stall) begin
            for (int l = 0; l < LANES; l++) begin
                for (int c = 0; c < CMT; c++) begin
                    if (iROB_en[c] && r_rs1_nick[l] != '0 && r_rs1_nick[l] == iROB_rd_nick[c]) begin
                        r_rs1_dt[l]   <= iROB_rd_dt[c];
                        r_rs1_nick[l] <= '0;
                    end
                    if (iROB_en[c] && r_rs2_nick[l] != '0 && r_rs2_nick[l] == iROB_rd_nick[c]) begin
                        r_rs2_dt[l]   <= iROB_rd_dt[c];
                        r_rs2_nick[l] <= '0;
                    end
                end
            end
        end else begin
            r_dp_en <= 1'b0;
        end
    end

    assign oDP_en       = r_dp_en;
    assign oDP_rs1_dt   = r_rs1_dt;
    assign oDP_rs2_dt   = r_rs2_dt;
    assign oDP_rs1_nick = r_rs1_nick;
    assign oDP_rs2_nick = r_rs2_nick;
    assign oDP_rd_regnm = r_rd_regnm;
    assign oDP_rd_we    = r_rd_we;
    assign oDP_nick     = r_nick;
    assign oDP_op       = r_op;
    assign oDP_pc       = r_pc;
    assign oDP_imm      = r_imm;
    assign oDP_pd       = r_pd;

endmodule

// File: tb/tb_regfile_rn.sv
// Scoreboard bench for regfile_rn: expected operand packets are queued at drive time
// and compared against the registered dispatch outputs one cycle later.
module tb_regfile_rn;
    import regfile_rn_pkg::*;

    logic clk = 1'b0;
    logic rst, rdy, clr, iIND_en, oIND_stall, oDP_en, iDP_stall;
    logic [1:0][4:0]  iIND_rs1_regnm, iIND_rs2_regnm, iIND_rd_regnm, oDP_rd_regnm;
    logic [1:0]       iIND_rd_we, iIND_pd, oDP_rd_we, oDP_pd;
    logic [1:0][3:0]  iIND_nick, oDP_rs1_nick, oDP_rs2_nick, oDP_nick;
    logic [1:0][OP_W-1:0]   iIND_op, oDP_op;
    logic [1:0][ADDR_W-1:0] iIND_pc, oDP_pc;
    logic [1:0][IMM_W-1:0]  iIND_imm, oDP_imm;
    logic [1:0][31:0] oDP_rs1_dt, oDP_rs2_dt;
    logic [1:0]       iROB_en;
    logic [1:0][4:0]  iROB_rd_regnm;
    logic [1:0][31:0] iROB_rd_dt;
    logic [1:0][3:0]  iROB_rd_nick;

    typedef struct packed {
        logic        en;
        logic [0:0]  lane;
        logic [31:0] rs1_dt;
        logic [3:0]  rs1_nick;
        logic [31:0] rs2_dt;
        logic [3:0]  rs2_nick;
    } exp_t;

    exp_t sb[$];
    exp_t e, o;
    int checks = 0;
    int errors = 0;

    regfile_rn dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clr(clr),
        .iIND_en(iIND_en), .oIND_stall(oIND_stall),
        .iIND_rs1_regnm(iIND_rs1_regnm), .iIND_rs2_regnm(iIND_rs2_regnm),
        .iIND_rd_regnm(iIND_rd_regnm), .iIND_rd_we(iIND_rd_we), .iIND_nick(iIND_nick),
        .iIND_op(iIND_op), .iIND_pc(iIND_pc), .iIND_imm(iIND_imm), .iIND_pd(iIND_pd),
        .oDP_en(oDP_en), .iDP_stall(iDP_stall),
        .oDP_rs1_dt(oDP_rs1_dt), .oDP_rs2_dt(oDP_rs2_dt),
        .oDP_rs1_nick(oDP_rs1_nick), .oDP_rs2_nick(oDP_rs2_nick),
        .oDP_rd_regnm(oDP_rd_regnm), .oDP_rd_we(oDP_rd_we), .oDP_nick(oDP_nick),
        .oDP_op(oDP_op), .oDP_pc(oDP_pc), .oDP_imm(oDP_imm), .oDP_pd(oDP_pd),
        .iROB_en(iROB_en), .iROB_rd_regnm(iROB_rd_regnm),
        .iROB_rd_dt(iROB_rd_dt), .iROB_rd_nick(iROB_rd_nick)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(int l, logic [31:0] d1, logic [3:0] n1, logic [31:0] d2, logic [3:0] n2);
        mk = '{en: 1'b1, lane: 1'(l), rs1_dt: d1, rs1_nick: n1, rs2_dt: d2, rs2_nick: n2};
    endfunction

    function automatic exp_t observe(logic [0:0] l);
        observe = '{en: oDP_en, lane: l, rs1_dt: oDP_rs1_dt[l], rs1_nick: oDP_rs1_nick[l],
                    rs2_dt: oDP_rs2_dt[l], rs2_nick: oDP_rs2_nick[l]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        iIND_en = 1'b0; iIND_rs1_regnm = '0; iIND_rs2_regnm = '0; iIND_rd_regnm = '0;
        iIND_rd_we = '0; iIND_nick = '0; iIND_op = '0; iIND_pc = '0; iIND_imm = '0; iIND_pd = '0;
        iROB_en = '0; iROB_rd_regnm = '0; iROB_rd_dt = '0; iROB_rd_nick = '0;
    endtask

    task automatic lane(int l, logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd, logic we, logic [3:0] nick);
        iIND_en = 1'b1;
        iIND_rs1_regnm[l] = rs1; iIND_rs2_regnm[l] = rs2; iIND_rd_regnm[l] = rd;
        iIND_rd_we[l] = we; iIND_nick[l] = nick;
        iIND_pc[l] = 32'h1000 + 32'(l * 4); iIND_op[l] = 8'(8'h30 + 8'(l));
    endtask

    task automatic cmt(int c, logic [4:0] rd, logic [31:0] dt, logic [3:0] nick);
        iROB_en[c] = 1'b1; iROB_rd_regnm[c] = rd; iROB_rd_dt[c] = dt; iROB_rd_nick[c] = nick;
    endtask

    task automatic test_reset();
        rst = 1'b0; rdy = 1'b1; clr = 1'b0; iDP_stall = 1'b0; idle();
        lane(0, 5'd5, 5'd0, 5'd0, 1'b0, 4'd0);
        repeat (2) step();
        checks++; if (oIND_stall !== 1'b1) begin errors++; $display("FAIL rst_stall got %b want 1", oIND_stall); end
        checks++; if (oDP_en !== 1'b0) begin errors++; $display("FAIL rst_dp_en got %b want 0", oDP_en); end
        rst = 1'b1; idle(); step();
        checks++; if (oDP_en !== 1'b0) begin errors++; $display("FAIL first_dp_en got %b want 0", oDP_en); end
        lane(0, 5'd5, 5'd5, 5'd0, 1'b0, 4'd0); lane(1, 5'd5, 5'd0, 5'd0, 1'b0, 4'd0);
        sb.push_back(mk(0, 0, 0, 0, 0)); sb.push_back(mk(1, 0, 0, 0, 0));
        step(); idle();
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = observe(e.lane); checks++;
            if (o !== e) begin errors++; $display("FAIL reset_read lane%0d got %h want %h", e.lane, o, e); end
        end
    endtask

    task automatic test_intra_group();
        lane(0, 5'd1, 5'd0, 5'd3, 1'b1, 4'd5); lane(1, 5'd3, 5'd2, 5'd4, 1'b1, 4'd6);
        sb.push_back(mk(1, 0, 5, 0, 0)); sb.push_back(mk(0, 0, 0, 0, 0));
        step(); idle();
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = observe(e.lane); checks++;
            if (o !== e) begin errors++; $display("FAIL intra lane%0d got %h want %h", e.lane, o, e); end
        end
        checks++; if (oDP_rd_we !== 2'b11 || oDP_nick[1] !== 4'd6 || oDP_pc[1] !== 32'h1004)
            begin errors++; $display("FAIL sideband got we=%b nick=%0d pc=%h want 11 6 1004", oDP_rd_we, oDP_nick[1], oDP_pc[1]); end
        lane(0, 5'd3, 5'd4, 5'd0, 1'b0, 4'd0);
        sb.push_back(mk(0, 0, 5, 0, 6));
        step(); idle();
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = observe(e.lane); checks++;
            if (o !== e) begin errors++; $display("FAIL rename_visible lane%0d got %h want %h", e.lane, o, e); end
        end
    endtask

    task automatic test_commit_bypass();
        lane(0, 5'd0, 5'd0, 5'd7, 1'b1, 4'd2); step(); idle();
        lane(0, 5'd7, 5'd3, 5'd0, 1'b0, 4'd0); cmt(0, 5'd7, 32'hDEAD, 4'd2);
        sb.push_back(mk(0, 32'hDEAD, 0, 0, 5));
        step(); idle();
        lane(0, 5'd3, 5'd3, 5'd0, 1'b0, 4'd0); cmt(0, 5'd3, 32'h11, 4'd5); cmt(1, 5'd3, 32'h22, 4'd5);
        sb.push_back(mk(0, 32'h22, 0, 32'h22, 0));
        while (sb.size() > 1) begin
            e = sb.pop_front(); o = observe(e.lane); checks++;
            if (o !== e) begin errors++; $display("FAIL commit_bypass lane%0d got %h want %h", e.lane, o, e); end
        end
        step(); idle();
        lane(0, 5'd7, 5'd3, 5'd0, 1'b0, 4'd0);
        sb.push_back(mk(0, 32'hDEAD, 0, 32'h22, 0));
        e = sb.pop_front(); o = observe(e.lane); checks++;
        if (o !== e) begin errors++; $display("FAIL commit_high_port lane%0d got %h want %h", e.lane, o, e); end
        step(); idle();
        e = sb.pop_front(); o = observe(e.lane); checks++;
        if (o !== e) begin errors++; $display("FAIL commit_visible lane%0d got %h want %h", e.lane, o, e); end
    endtask

    task automatic test_stale_commit();
        lane(0, 5'd0, 5'd0, 5'd7, 1'b1, 4'd4); step(); idle();
        lane(0, 5'd7, 5'd0, 5'd0, 1'b0, 4'd0); cmt(0, 5'd7, 32'hBEEF, 4'd2);
        sb.push_back(mk(0, 32'hBEEF, 4, 0, 0));
        step(); idle();
        lane(0, 5'd7, 5'd0, 5'd0, 1'b0, 4'd0);
        sb.push_back(mk(0, 32'hBEEF, 4, 0, 0));
        e = sb.pop_front(); o = observe(e.lane); checks++;
        if (o !== e) begin errors++; $display("FAIL stale_bypass lane%0d got %h want %h", e.lane, o, e); end
        step(); idle();
        lane(0, 5'd0, 5'd0, 5'd7, 1'b1, 4'd9); lane(1, 5'd7, 5'd0, 5'd0, 1'b0, 4'd0);
        cmt(0, 5'd7, 32'hCAFE, 4'd4);
        sb.push_back(mk(1, 0, 9, 0, 0));
        e = sb.pop_front(); o = observe(e.lane); checks++;
        if (o !== e) begin errors++; $display("FAIL stale_keep lane%0d got %h want %h", e.lane, o, e); end
        step(); idle();
        lane(0, 5'd7, 5'd0, 5'd0, 1'b0, 4'd0);
        sb.push_back(mk(0, 32'hCAFE, 9, 0, 0));
        e = sb.pop_front(); o = observe(e.lane); checks++;
        if (o !== e) begin errors++; $display("FAIL rename_intra lane%0d got %h want %h", e.lane, o, e); end
        step(); idle();
        e = sb.pop_front(); o = observe(e.lane); checks++;
        if (o !== e) begin errors++; $display("FAIL rename_beats_clear lane%0d got %h want %h", e.lane, o, e); end
    endtask

    task automatic test_stall_snoop();
        lane(0, 5'd0, 5'd4, 5'd0, 1'b0, 4'd0);
        sb.push_back(mk(0, 0, 0, 0, 6));
        step(); idle();
        e = sb.pop_front(); o = observe(e.lane); checks++;
        if (o !== e) begin errors++; $display("FAIL snoop_capture lane%0d got %h want %h", e.lane, o, e); end
        iDP_stall = 1'b1; lane(0, 5'd4, 5'd0, 5'd0, 1'b0, 4'd0); cmt(0, 5'd4, 32'h55, 4'd6);
        #1;
        checks++; if (oIND_stall !== 1'b1) begin errors++; $display("FAIL snoop_stall_a got %b want 1", oIND_stall); end
        sb.push_back(mk(0, 0, 0, 32'h55, 0));
        step();
        checks++; if (oIND_stall !== 1'b1) begin errors++; $display("FAIL snoop_stall_b got %b want 1", oIND_stall); end
        e = sb.pop_front(); o = observe(e.lane); checks++;
        if (o !== e) begin errors++; $display("FAIL snoop_hold lane%0d got %h want %h", e.lane, o, e); end
        iROB_en = '0; iDP_stall = 1'b0;
        #1;
        checks++; if (oIND_stall !== 1'b0) begin errors++; $display("FAIL snoop_release got %b want 0", oIND_stall); end
        sb.push_back(mk(0, 32'h55, 0, 0, 0));
        step(); idle();
        e = sb.pop_front(); o = observe(e.lane); checks++;
        if (o !== e) begin errors++; $display("FAIL snoop_next lane%0d got %h want %h", e.lane, o, e); end
        step();
        checks++; if (oDP_en !== 1'b0) begin errors++; $display("FAIL dp_en_drop got %b want 0", oDP_en); end
    endtask

    task automatic test_flush();
        lane(0, 5'd0, 5'd0, 5'd9, 1'b1, 4'd3); step(); idle();
        clr = 1'b1; lane(0, 5'd0, 5'd0, 5'd10, 1'b1, 4'd7); cmt(0, 5'd9, 32'd1, 4'd8);
        #1;
        checks++; if (oIND_stall !== 1'b1) begin errors++; $display("FAIL clr_stall got %b want 1", oIND_stall); end
        step(); clr = 1'b0; idle();
        checks++; if (oDP_en !== 1'b0) begin errors++; $display("FAIL clr_dp_en got %b want 0", oDP_en); end
        lane(0, 5'd9, 5'd10, 5'd0, 1'b0, 4'd0); lane(1, 5'd7, 5'd3, 5'd0, 1'b0, 4'd0);
        sb.push_back(mk(0, 32'd1, 0, 0, 0)); sb.push_back(mk(1, 32'hCAFE, 0, 32'h22, 0));
        step(); idle();
        while (sb.size() > 0) begin
            e = sb.pop_front(); o = observe(e.lane); checks++;
            if (o !== e) begin errors++; $display("FAIL flush_read lane%0d got %h want %h", e.lane, o, e); end
        end
    endtask

    task automatic test_x0_and_rdy();
        lane(0, 5'd0, 5'd0, 5'd0, 1'b1, 4'd5); lane(1, 5'd0, 5'd0, 5'd0, 1'b0, 4'd0);
        cmt(0, 5'd0, 32'hFFFF, 4'd1);
        sb.push_back(mk(1, 0, 0, 0, 0));
        step(); idle();
        e = sb.pop_front(); o = observe(e.lane); checks++;
        if (o !== e) begin errors++; $display("FAIL x0_read lane%0d got %h want %h", e.lane, o, e); end
        rdy = 1'b0; lane(0, 5'd12, 5'd0, 5'd12, 1'b1, 4'd3);
        #1;
        checks++; if (oIND_stall !== 1'b1) begin errors++; $display("FAIL rdy_stall got %b want 1", oIND_stall); end
        idle(); cmt(0, 5'd12, 32'h77, 4'd0);
        step(); idle();
        checks++; if (oDP_en !== 1'b1) begin errors++; $display("FAIL rdy_hold got %b want 1", oDP_en); end
        rdy = 1'b1;
        lane(0, 5'd12, 5'd0, 5'd0, 1'b0, 4'd0);
        sb.push_back(mk(0, 0, 0, 0, 0));
        step(); idle();
        e = sb.pop_front(); o = observe(e.lane); checks++;
        if (o !== e) begin errors++; $display("FAIL rdy_frozen lane%0d got %h want %h", e.lane, o, e); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            lane(0, 5'(19 + i), 5'd0, 5'(20 + i), 1'b1, 4'(i + 1));
            lane(1, 5'(20 + i), 5'd0, 5'd0, 1'b0, 4'd0);
            sb.push_back(mk(0, 0, 4'(i), 0, 0)); sb.push_back(mk(1, 0, 4'(i + 1), 0, 0));
            #1;
            checks++; if (oIND_stall !== 1'b0) begin errors++; $display("FAIL b2b_stall%0d got %b want 0", i, oIND_stall); end
            step();
            while (sb.size() > 0) begin
                e = sb.pop_front(); o = observe(e.lane); checks++;
                if (o !== e) begin errors++; $display("FAIL b2b%0d lane%0d got %h want %h", i, e.lane, o, e); end
            end
        end
        idle(); step();
        checks++; if (oDP_en !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b want 0", oDP_en); end
    endtask

    initial begin
        test_reset();
        test_intra_group();
        test_commit_bypass();
        test_stale_commit();
        test_stall_snoop();
        test_flush();
        test_x0_and_rdy();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
